// File: rtl/maxpool_stream.sv
// 2x2 stride-2 max-pool over a raster CHANNELS-wide pixel stream.
// Define MAXPOOL_RELU_EN to clamp negative pooled values to zero (SIGNED=1).
module maxpool_stream #(
    parameter int CHANNELS = 8,
    parameter int DATA_W   = 8,
    parameter int WIDTH    = 26,
    parameter int HEIGHT   = 26,
    parameter int SIGNED   = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    output logic                         out_valid,
    output logic [CHANNELS*DATA_W-1:0]   out_data,
    output logic                         frame_done
);

    localparam int OUT_W = WIDTH / 2;
    localparam int BUS_W = CHANNELS * DATA_W;
    localparam int CW    = $clog2(WIDTH);
    localparam int RW    = $clog2(HEIGHT);
    localparam int LBW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam bit ODD_W = (WIDTH % 2) != 0;
    localparam bit ODD_H = (HEIGHT % 2) != 0;
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [BUS_W-1:0] r_hold;
    logic [BUS_W-1:0] r_linebuf [OUT_W];
    logic             r_out_valid;
    logic [BUS_W-1:0] r_out_data;
    logic             r_frame_done;

    logic             w_col_last;
    logic             w_row_last;
    logic             w_col_in;
    logic             w_row_in;
    logic             w_hold_en;
    logic             w_pair;
    logic             w_lb_en;
    logic             w_out_en;
    logic [LBW-1:0]   w_lb_idx;
    logic [BUS_W-1:0] w_lb_rd;
    logic [BUS_W-1:0] w_hmax;
    logic [BUS_W-1:0] w_vmax;
    logic [BUS_W-1:0] w_pool;

    function automatic logic [DATA_W-1:0] f_max(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic gt;
        if (SIGNED != 0) gt = $signed(a) > $signed(b);
        else             gt = a > b;
        return gt ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] f_relu(
        input logic [DATA_W-1:0] a
    );
`ifdef MAXPOOL_RELU_EN
        if ((SIGNED != 0) && a[DATA_W-1]) return '0;
`endif
        return a;
    endfunction

    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);
    // Trailing odd column/row is counted but never enters the datapath.
    assign w_col_in   = !ODD_W || !w_col_last;
    assign w_row_in   = !ODD_H || !w_row_last;
    assign w_hold_en  = in_valid && w_col_in && !r_col[0];
    assign w_pair     = in_valid && w_col_in && w_row_in && r_col[0];
    assign w_lb_en    = w_pair && !r_row[0];
    assign w_out_en   = w_pair && r_row[0];
    assign w_lb_idx   = LBW'(r_col >> 1);
    assign w_lb_rd    = r_linebuf[w_lb_idx];

    always_comb begin
        w_hmax = '0;
        w_vmax = '0;
        w_pool = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_hmax[c*DATA_W +: DATA_W] =
                f_max(r_hold[c*DATA_W +: DATA_W],
                      in_data[c*DATA_W +: DATA_W]);
            w_vmax[c*DATA_W +: DATA_W] =
                f_max(w_lb_rd[c*DATA_W +: DATA_W],
                      w_hmax[c*DATA_W +: DATA_W]);
            w_pool[c*DATA_W +: DATA_W] =
                f_relu(w_vmax[c*DATA_W +: DATA_W]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (in_valid) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_out_valid  <= w_out_en;
            r_frame_done <= in_valid && w_col_last && w_row_last;
            if (w_out_en) r_out_data <= w_pool;
        end
    end

    // Datapath storage is always written before it is read within a frame.
    always_ff @(posedge clk) begin
        if (w_hold_en) r_hold <= in_data;
        if (w_lb_en)   r_linebuf[w_lb_idx] <= w_hmax;
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_maxpool_stream.sv
// Bench for maxpool_stream: four instances with different geometries,
// checked against a frame-level pooling model.
module tb_maxpool_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld;
    logic [63:0] din;
    int          sel;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        va, vb, vc, vd;
    logic        ov_a, ov_b, ov_c, ov_d;
    logic        fd_a, fd_b, fd_c, fd_d;
    logic [7:0]  od_a;
    logic [15:0] od_b;
    logic [7:0]  od_c;
    logic [63:0] od_d;

    assign va = vld && (sel == 0);
    assign vb = vld && (sel == 1);
    assign vc = vld && (sel == 2);
    assign vd = vld && (sel == 3);

    maxpool_stream #(.CHANNELS(1), .DATA_W(8), .WIDTH(4),
                     .HEIGHT(4), .SIGNED(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(va), .in_data(din[7:0]),
        .out_valid(ov_a), .out_data(od_a), .frame_done(fd_a));

    maxpool_stream #(.CHANNELS(2), .DATA_W(8), .WIDTH(5),
                     .HEIGHT(5), .SIGNED(0)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_data(din[15:0]),
        .out_valid(ov_b), .out_data(od_b), .frame_done(fd_b));

    maxpool_stream #(.CHANNELS(1), .DATA_W(8), .WIDTH(2),
                     .HEIGHT(2), .SIGNED(1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(vc), .in_data(din[7:0]),
        .out_valid(ov_c), .out_data(od_c), .frame_done(fd_c));

    maxpool_stream #(.CHANNELS(8), .DATA_W(8), .WIDTH(26),
                     .HEIGHT(26), .SIGNED(0)) u_d (
        .clk(clk), .rst_n(rst_n), .in_valid(vd), .in_data(din),
        .out_valid(ov_d), .out_data(od_d), .frame_done(fd_d));

    logic        ov_m, fd_m;
    logic [63:0] od_m;

    always_comb begin
        ov_m = 1'b0;
        fd_m = 1'b0;
        od_m = '0;
        case (sel)
            0: begin ov_m = ov_a; fd_m = fd_a; od_m = {56'd0, od_a}; end
            1: begin ov_m = ov_b; fd_m = fd_b; od_m = {48'd0, od_b}; end
            2: begin ov_m = ov_c; fd_m = fd_c; od_m = {56'd0, od_c}; end
            default: begin ov_m = ov_d; fd_m = fd_d; od_m = od_d; end
        endcase
    end

    logic [63:0] frm[$];
    logic [63:0] exq[$];
    int          eidx[$];
    int          cap[$];
    logic [63:0] oq[$];
    int          ocq[$];
    int          fq[$];
    int          stray = 0;
    int          n_chk = 0;
    int          n_err = 0;

    always @(negedge clk) begin
        int tot;
        if (ov_m) begin
            oq.push_back(od_m);
            ocq.push_back(cyc);
        end
        if (fd_m) fq.push_back(cyc);
        tot = int'(ov_a) + int'(ov_b) + int'(ov_c) + int'(ov_d)
            + int'(fd_a) + int'(fd_b) + int'(fd_c) + int'(fd_d);
        stray += tot - int'(ov_m) - int'(fd_m);
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint fld(input logic [63:0] p, input int c,
                                   input int dw, input int sg);
        logic [63:0] m;
        m = (p >> (c * dw)) & ((64'd1 << dw) - 64'd1);
        if (sg != 0 && m[dw-1]) return longint'(m) - (longint'(1) << dw);
        return longint'(m);
    endfunction

    task automatic model(input int w, input int h, input int ch,
                         input int dw, input int sg, input int nf);
        int          k;
        longint      m;
        logic [63:0] r;
        logic [63:0] u;
        exq.delete();
        eidx.delete();
        for (int f = 0; f < nf; f++)
            for (int oy = 0; oy < h / 2; oy++)
                for (int ox = 0; ox < w / 2; ox++) begin
                    k = f * w * h + 2 * oy * w + 2 * ox;
                    r = '0;
                    for (int c = 0; c < ch; c++) begin
                        m = fld(frm[k], c, dw, sg);
                        if (fld(frm[k+1], c, dw, sg) > m)
                            m = fld(frm[k+1], c, dw, sg);
                        if (fld(frm[k+w], c, dw, sg) > m)
                            m = fld(frm[k+w], c, dw, sg);
                        if (fld(frm[k+w+1], c, dw, sg) > m)
                            m = fld(frm[k+w+1], c, dw, sg);
`ifdef MAXPOOL_RELU_EN
                        if (sg != 0 && m < 0) m = 0;
`endif
                        u = m;
                        u = u & ((64'd1 << dw) - 64'd1);
                        r = r | (u << (c * dw));
                    end
                    exq.push_back(r);
                    eidx.push_back(k + w + 1);
                end
    endtask

    task automatic drive(input int gaps);
        int n;
        cap.delete();
        oq.delete();
        ocq.delete();
        fq.delete();
        foreach (frm[i]) begin
            if (gaps != 0) begin
                n = $urandom_range(0, 2);
                repeat (n) begin
                    @(negedge clk);
                    vld = 1'b0;
                end
            end
            @(negedge clk);
            vld = 1'b1;
            din = frm[i];
            cap.push_back(cyc + 1);
        end
        @(negedge clk);
        vld = 1'b0;
        din = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic run(input int s, input int w, input int h,
                       input int ch, input int sg, input int nf,
                       input int gaps);
        model(w, h, ch, 8, sg, nf);
        drive(gaps);
        chk($sformatf("s%0d.count", s), 64'(oq.size()), 64'(exq.size()));
        foreach (exq[i]) begin
            chk($sformatf("s%0d.data%0d", s, i), oq[i], exq[i]);
            chk($sformatf("s%0d.lat%0d", s, i),
                64'(ocq[i]), 64'(cap[eidx[i]]));
        end
        chk($sformatf("s%0d.fdcount", s), 64'(fq.size()), 64'(nf));
        for (int f = 0; f < nf; f++)
            chk($sformatf("s%0d.fd%0d", s, f),
                64'(fq[f]), 64'(cap[(f + 1) * w * h - 1]));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".ov"}, {ov_a, ov_b, ov_c, ov_d}, 64'd0);
        chk({tag, ".fd"}, {fd_a, fd_b, fd_c, fd_d}, 64'd0);
        chk({tag, ".oda"}, {56'd0, od_a}, 64'd0);
        chk({tag, ".odb"}, {48'd0, od_b}, 64'd0);
        chk({tag, ".odc"}, {56'd0, od_c}, 64'd0);
        chk({tag, ".odd"}, od_d, 64'd0);
    endtask

    logic [63:0] lit_a [4];
    logic [63:0] lit_b [4];
    logic [63:0] lit_c;

    initial begin
        lit_a = '{64'd5, 64'd7, 64'd13, 64'd15};
        lit_b = '{64'h1806, 64'h1608, 64'h0E10, 64'h0C12};
`ifdef MAXPOOL_RELU_EN
        lit_c = 64'h00;
`else
        lit_c = 64'hFF;
`endif
        rst_n = 1'b0;
        vld   = 1'b0;
        din   = '0;
        sel   = 0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst_n = 1'b1;

        frm.delete();
        for (int i = 0; i < 16; i++) frm.push_back(64'(i));
        run(0, 4, 4, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("a.lit%0d", i), oq[i], lit_a[i]);
        chk("a.hold", {56'd0, od_a}, 64'd15);

        run(0, 4, 4, 1, 0, 1, 1);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vld = 1'b1;
            din = 64'(200 + i);
        end
        @(negedge clk);
        vld   = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk_idle("midrst");
        rst_n = 1'b1;
        run(0, 4, 4, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("a.rst%0d", i), oq[i], lit_a[i]);

        sel = 1;
        frm.delete();
        for (int i = 0; i < 25; i++)
            frm.push_back((64'(24 - i) << 8) | 64'(i));
        run(1, 5, 5, 2, 0, 1, 0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("b.lit%0d", i), oq[i], lit_b[i]);

        sel = 2;
        frm.delete();
        frm.push_back(64'hFD);
        frm.push_back(64'hFF);
        frm.push_back(64'hF9);
        frm.push_back(64'hFE);
        for (int i = 0; i < 24; i++)
            frm.push_back(64'($urandom_range(0, 255)));
        run(2, 2, 2, 1, 1, 7, 1);
        chk("c.lit", oq[0], lit_c);

        sel = 3;
        frm.delete();
        for (int i = 0; i < 2 * 26 * 26; i++)
            frm.push_back({$urandom, $urandom});
        run(3, 26, 26, 8, 0, 2, 0);

        chk("stray", 64'(stray), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/maxpool_stream.md
Name: maxpool_stream

Overview:
- Parametrised 2x2, stride-2 max-pooling layer for the MNIST CNN pipeline. Generalises the fixed per-channel pooling stages to any channel count, data width and frame size.
- Consumes a raster-order pixel stream of CHANNELS packed values from a conv layer and emits a raster-order pooled stream to the next conv or FC layer.
- Odd frame dimensions are handled by dropping the trailing row/column (11x11 -> 5x5).

Parameters:
- CHANNELS, 8, number of parallel feature channels.
- DATA_W, 8, bits per channel value.
- WIDTH, 26, input frame width in pixels (>= 2).
- HEIGHT, 26, input frame height in pixels (>= 2).
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned compare.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies in_data this cycle; no backpressure.
- in_data  input  CHANNELS*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
- out_valid  output  1  qualifies out_data, single-cycle pulse per pooled pixel.
- out_data  output  CHANNELS*DATA_W  pooled pixel, same packing as in_data.
- frame_done  output  1  one-cycle pulse after the last input pixel of a frame.

Behaviour:
- Derived values: OUT_W = WIDTH/2, OUT_H = HEIGHT/2 (floor).
- Reset: async on rst_n low. out_valid=0, out_data=0, frame_done=0, col=0, row=0, hold registers and line buffer contents don't-care.
- Counters:
  - col advances 0..WIDTH-1 only on in_valid.
  - At WIDTH-1, col wraps to 0 and row increments.
  - At row HEIGHT-1 / col WIDTH-1, both wrap to 0.
  - Idle cycles (in_valid=0) change no state.
- Horizontal stage, per channel, only when col < 2*OUT_W:
  - Even col: hold <= in.
  - Odd col: hmax = max(hold, in).
- Vertical stage, only when row < 2*OUT_H:
  - Even row: linebuf[col>>1] <= hmax (OUT_W entries, CHANNELS*DATA_W bits each).
  - Odd row: out_data <= max(linebuf[col>>1], hmax), out_valid <= 1.
- Latency: out_valid asserts the cycle after the in_valid cycle carrying the odd-row, odd-col pixel. Otherwise out_valid=0. out_data holds its last value when out_valid=0.
- Trailing column (col = WIDTH-1 when WIDTH is odd) and trailing row (row = HEIGHT-1 when HEIGHT is odd) are counted but never stored or output.
- frame_done: 1 the cycle after the final pixel (row HEIGHT-1, col WIDTH-1) is accepted. It may coincide with the last out_valid when both dimensions are even.
- Compare: ties keep either operand (equal values). SIGNED=1 uses a signed compare over DATA_W bits. No width growth: out width equals in width.
- Back-to-back frames: the first pixel of frame N+1 may arrive the cycle after the last pixel of frame N, with no bubble required.
- Reset mid-frame discards the partial frame. The next accepted pixel is treated as row 0, col 0.
- Exactly OUT_W*OUT_H out_valid pulses per frame.

Optional Feature:
- Macro MAXPOOL_RELU_EN.
- Defined: each output channel value is clamped to 0 if negative (only meaningful when SIGNED=1; no effect when SIGNED=0). This fuses the ReLU ahead of the pool output register, adding no latency.
- Undefined: raw max is output unchanged.

Test Plan:
- 4x4, CHANNELS=1, unsigned, input 0..15 raster -> outputs 5,7,13,15 in order. 4 out_valid pulses; frame_done 1 cycle after pixel 15.
- 5x5, CHANNELS=2, ch0 = index, ch1 = 24-index -> 4 outputs: ch0 6,8,16,18; ch1 24,22,14,12. Row 4 and col 4 are ignored; frame_done after the 25th pixel.
- SIGNED=1, DATA_W=8, 2x2 frame {-3,-1,-7,-2} -> out -1. With MAXPOOL_RELU_EN defined -> out 0.
- 4x4 stream with in_valid toggling 1,0,1,0 (random gaps) -> same outputs as the gapless case. No out_valid on idle cycles.
- Two back-to-back 26x26 frames, CHANNELS=8, random data -> 169 pulses per frame matching the reference model; two frame_done pulses.
- Assert rst_n low after 10 pixels of a 4x4 frame, then release and send a full frame 0..15 -> outputs 5,7,13,15 only, with no stale data.
